// File: rtl/branch_hit_counter_if.sv
// Sample, branch-report and dump bus of the branch hit counter.
interface branch_hit_counter_if #(
  parameter int unsigned N_COND = 2,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned IDX_W = $clog2(N_COND + 1);

  logic              sample_valid;
  logic              sample_ready;
  logic [N_COND-1:0] cond;
  logic              br_valid;
  logic [IDX_W-1:0]  br_idx;
  logic              clear;
  logic              dump_start;
  logic              dump_valid;
  logic              dump_ready;
  logic [IDX_W-1:0]  dump_idx;
  logic [CNT_W-1:0]  dump_cnt;
  logic              dump_last;
  logic              all_hit;
  logic [N_COND:0]   sat;

  // Producer of samples and consumer of dump beats.
  modport master (
    output sample_valid, cond, clear, dump_start, dump_ready,
    input  sample_ready, br_valid, br_idx, dump_valid, dump_idx,
           dump_cnt, dump_last, all_hit, sat
  );

  // The counter block itself.
  modport slave (
    input  sample_valid, cond, clear, dump_start, dump_ready,
    output sample_ready, br_valid, br_idx, dump_valid, dump_idx,
           dump_cnt, dump_last, all_hit, sat
  );
endinterface

// File: rtl/branch_hit_counter.sv
// Per-branch hit counters for an if/else-if chain with a streaming dump port.
module branch_hit_counter #(
  parameter int unsigned N_COND = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  branch_hit_counter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_COND + 1);
  localparam int unsigned N_BR  = N_COND + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COND);

  typedef enum logic {S_IDLE, S_DUMP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt [N_BR];
  logic [N_BR-1:0]   r_sat;
  logic              r_all_hit;
  logic              r_br_valid;
  logic [IDX_W-1:0]  r_br_idx;
  logic [IDX_W-1:0]  r_dump_idx;

  logic              w_ready;
  logic              w_accept;
  logic              w_dump_valid;
  logic              w_dump_last;
  logic              w_dump_hs;
  logic [IDX_W-1:0]  w_sel;
  logic [CNT_W-1:0]  w_dump_cnt;
  logic              w_all_nz;

  assign w_ready      = (r_state == S_IDLE);
  assign w_accept     = bus.sample_valid && w_ready;
  assign w_dump_valid = (r_state == S_DUMP);
  assign w_dump_last  = w_dump_valid && (r_dump_idx == LAST_IDX);
  assign w_dump_hs    = w_dump_valid && bus.dump_ready;

  // Priority select: lowest set condition wins, none set means else.
  always_comb begin
    w_sel = LAST_IDX;
    for (int i = int'(N_COND) - 1; i >= 0; i--) begin
      if (bus.cond[i]) w_sel = IDX_W'(i);
    end
  end

  // Every branch has been hit at least once.
  always_comb begin
    w_all_nz = 1'b1;
    for (int i = 0; i < int'(N_BR); i++) begin
      if (r_cnt[i] == '0) w_all_nz = 1'b0;
    end
  end

  // Live read of the counter addressed by the dump pointer.
  always_comb begin
    w_dump_cnt = '0;
    for (int i = 0; i < int'(N_BR); i++) begin
      if (r_dump_idx == IDX_W'(i)) w_dump_cnt = r_cnt[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: clear always returns to idle, last handshake ends the dump.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.dump_start) w_state_nxt = S_DUMP;
        S_DUMP: if (w_dump_hs && w_dump_last) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Counters, saturation flags and the lagging all-hit flag; clear beats a same-cycle sample.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      for (int i = 0; i < int'(N_BR); i++) r_cnt[i] <= '0;
      r_sat     <= '0;
      r_all_hit <= 1'b0;
    end else begin
      r_all_hit <= w_all_nz;
      for (int i = 0; i < int'(N_BR); i++) begin
        if (w_accept && (w_sel == IDX_W'(i)) && (r_cnt[i] != CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          if (r_cnt[i] == CNT_MAX - CNT_W'(1)) r_sat[i] <= 1'b1;
        end
      end
    end
  end

  // Branch report: one pulse per accepted sample, index held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_valid <= 1'b0;
      r_br_idx   <= '0;
    end else begin
      r_br_valid <= w_accept;
      if (w_accept) r_br_idx <= w_sel;
    end
  end

  // Dump pointer: rests at 0 outside a dump, advances on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst || bus.clear || !w_dump_valid) begin
      r_dump_idx <= '0;
    end else if (w_dump_hs) begin
      r_dump_idx <= w_dump_last ? '0 : r_dump_idx + IDX_W'(1);
    end
  end

  assign bus.sample_ready = w_ready;
  assign bus.br_valid     = r_br_valid;
  assign bus.br_idx       = r_br_idx;
  assign bus.dump_valid   = w_dump_valid;
  assign bus.dump_idx     = r_dump_idx;
  assign bus.dump_cnt     = w_dump_cnt;
  assign bus.dump_last    = w_dump_last;
  assign bus.all_hit      = r_all_hit;
  assign bus.sat          = r_sat;
endmodule

// File: tb/tb_branch_hit_counter.sv
// Directed and randomized checks of branch_hit_counter against a behavioural model.
module tb_branch_hit_counter;
  localparam int N   = 2;
  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;

  branch_hit_counter_if #(.N_COND(N), .CNT_W(W)) bus ();

  branch_hit_counter #(.N_COND(N), .CNT_W(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  int m_cnt [N+1];
  bit [N:0] m_sat;
  bit m_all;
  bit m_bv;
  int m_bidx;
  bit m_dump;
  int m_didx;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the rules of the block.
  task automatic model_tick(input bit r, input bit sv, input bit [N-1:0] c,
                            input bit clr, input bit ds, input bit dr);
    bit acc;
    bit every;
    int sel;
    acc = sv && !m_dump;
    sel = N;
    for (int i = N - 1; i >= 0; i--) if (c[i]) sel = i;
    if (r) begin
      for (int i = 0; i <= N; i++) m_cnt[i] = 0;
      m_sat = '0; m_all = 0; m_bv = 0; m_bidx = 0; m_dump = 0; m_didx = 0;
      return;
    end
    m_bv = acc;
    if (acc) m_bidx = sel;
    if (clr) begin
      for (int i = 0; i <= N; i++) m_cnt[i] = 0;
      m_sat = '0; m_all = 0; m_dump = 0; m_didx = 0;
      return;
    end
    every = 1;
    for (int i = 0; i <= N; i++) if (m_cnt[i] == 0) every = 0;
    m_all = every;
    if (acc && m_cnt[sel] < MAX) begin
      m_cnt[sel]++;
      if (m_cnt[sel] == MAX) m_sat[sel] = 1'b1;
    end
    if (!m_dump) begin
      if (ds) begin m_dump = 1; m_didx = 0; end
    end else if (dr) begin
      if (m_didx == N) begin m_dump = 0; m_didx = 0; end
      else m_didx++;
    end
  endtask

  task automatic compare_all();
    chk("sample_ready", 32'(bus.sample_ready), 32'(!m_dump));
    chk("br_valid",     32'(bus.br_valid),     32'(m_bv));
    chk("br_idx",       32'(bus.br_idx),       32'(m_bidx));
    chk("dump_valid",   32'(bus.dump_valid),   32'(m_dump));
    chk("dump_idx",     32'(bus.dump_idx),     32'(m_didx));
    chk("dump_last",    32'(bus.dump_last),    32'(m_dump && m_didx == N));
    if (m_dump) chk("dump_cnt", 32'(bus.dump_cnt), 32'(m_cnt[m_didx]));
    chk("all_hit",      32'(bus.all_hit),      32'(m_all));
    chk("sat",          32'(bus.sat),          32'(m_sat));
  endtask

  // Drive one cycle at the falling edge, model it at the rising edge, check at the next falling edge.
  task automatic step(input bit r, input bit sv, input bit [N-1:0] c,
                      input bit clr, input bit ds, input bit dr);
    rst = r;
    bus.sample_valid = sv;
    bus.cond         = c;
    bus.clear        = clr;
    bus.dump_start   = ds;
    bus.dump_ready   = dr;
    @(posedge clk);
    model_tick(r, sv, c, clr, ds, dr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic sample(input bit [N-1:0] c);
    step(0, 1, c, 0, 0, 0);
  endtask

  task automatic beat(input bit dr);
    step(0, 0, 2'b00, 0, 0, dr);
  endtask

  initial begin
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.cond         = '0;
    bus.clear        = 1'b0;
    bus.dump_start   = 1'b0;
    bus.dump_ready   = 1'b0;
    for (int i = 0; i <= N; i++) m_cnt[i] = 0;
    m_sat = '0; m_all = 0; m_bv = 0; m_bidx = 0; m_dump = 0; m_didx = 0;
    @(negedge clk);

    // Reset values.
    step(1, 1, 2'b01, 1, 1, 1);
    chk("rst_ready", 32'(bus.sample_ready), 32'd1);
    chk("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
    chk("rst_all_hit", 32'(bus.all_hit), 32'd0);
    chk("rst_br_valid", 32'(bus.br_valid), 32'd0);

    // Basic counting and a full dump.
    sample(2'b00); sample(2'b01); sample(2'b00); sample(2'b10);
    step(0, 0, 2'b00, 0, 1, 1);
    chk("d036_b0_idx", 32'(bus.dump_idx), 32'd0);
    chk("d036_b0_cnt", 32'(bus.dump_cnt), 32'd1);
    chk("d036_all_hit", 32'(bus.all_hit), 32'd1);
    beat(1);
    chk("d036_b1_cnt", 32'(bus.dump_cnt), 32'd1);
    beat(1);
    chk("d036_b2_idx", 32'(bus.dump_idx), 32'd2);
    chk("d036_b2_cnt", 32'(bus.dump_cnt), 32'd2);
    chk("d036_b2_last", 32'(bus.dump_last), 32'd1);
    beat(1);
    chk("d036_end", 32'(bus.dump_valid), 32'd0);

    // Priority selection and report latency.
    sample(2'b11);
    chk("d037_11", 32'(bus.br_idx), 32'd0);
    sample(2'b10);
    chk("d037_10", 32'(bus.br_idx), 32'd1);
    sample(2'b00);
    chk("d037_00", 32'(bus.br_idx), 32'd2);
    chk("d037_bv", 32'(bus.br_valid), 32'd1);
    idle();
    chk("d037_bv_drop", 32'(bus.br_valid), 32'd0);

    // Saturation of branch 1 without wrap.
    step(0, 0, 2'b00, 1, 0, 0);
    for (int k = 0; k < 20; k++) sample(2'b10);
    chk("d038_sat", 32'(bus.sat), 32'b010);
    step(0, 0, 2'b00, 0, 1, 0);
    beat(1);
    chk("d038_cnt1", 32'(bus.dump_cnt), 32'd15);

    // Back-pressure on beat 1; samples during the dump are dropped.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 2'b00, 0, 0, 0);
      chk("d039_hold_idx", 32'(bus.dump_idx), 32'd1);
      chk("d039_hold_cnt", 32'(bus.dump_cnt), 32'd15);
    end
    beat(1);
    chk("d039_cnt2", 32'(bus.dump_cnt), 32'd0);
    beat(1);

    // Clear aborts a dump and zeros everything.
    sample(2'b00); sample(2'b01); idle();
    chk("d040_all_hit_pre", 32'(bus.all_hit), 32'd1);
    step(0, 0, 2'b00, 0, 1, 0);
    beat(1);
    step(0, 0, 2'b00, 1, 0, 0);
    chk("d040_abort", 32'(bus.dump_valid), 32'd0);
    chk("d040_ready", 32'(bus.sample_ready), 32'd1);
    chk("d040_all_hit", 32'(bus.all_hit), 32'd0);
    step(0, 0, 2'b00, 0, 1, 0);
    for (int k = 0; k <= N; k++) begin
      chk("d040_zero", 32'(bus.dump_cnt), 32'd0);
      beat(1);
    end

    // Reset in the middle of a dump.
    sample(2'b01); sample(2'b01); sample(2'b01);
    sample(2'b10); sample(2'b10); sample(2'b00);
    step(0, 0, 2'b00, 0, 1, 0);
    chk("d041_pre_cnt0", 32'(bus.dump_cnt), 32'd3);
    beat(1);
    chk("d041_pre_cnt1", 32'(bus.dump_cnt), 32'd2);
    step(1, 1, 2'b01, 0, 1, 1);
    chk("d041_rst_dv", 32'(bus.dump_valid), 32'd0);
    chk("d041_rst_idx", 32'(bus.dump_idx), 32'd0);
    chk("d041_rst_sat", 32'(bus.sat), 32'd0);
    idle();
    step(0, 0, 2'b00, 0, 1, 0);
    for (int k = 0; k <= N; k++) begin
      chk("d041_idx", 32'(bus.dump_idx), 32'(k));
      chk("d041_zero", 32'(bus.dump_cnt), 32'd0);
      beat(1);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) < 7),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
